// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-shares one active-low segment bus between
// NUM_DIGITS digit registers written from the CPU side. Each digit is shown
// for max(div,1) cycles, then a blank gap of GAP_CYCLES cycles follows.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   wr_en           one-cycle register write strobe
//   wr_addr         0..NUM_DIGITS-1 digit regs, 8 ctrl, 9 div low, 10 div high
//   wr_data         write data
//   an              digit selects, active-low, at most one low
//   seg             segments, active-low, bit7 = dp, bits6:0 = gfedcba
//   frame_start     pulse on the first SHOW cycle of digit 0
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 50000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [7:0]            wr_data,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            seg,
  output logic                  frame_start
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int CW = (DIV_WIDTH > GW) ? DIV_WIDTH : GW;
  localparam int EW = (DIV_WIDTH > 16) ? DIV_WIDTH : 16;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  // digit reg: [3:0] hex, [4] dp, [5] blank
  logic [NUM_DIGITS-1:0][5:0] dig_q, dig_d;
  logic                       en_q, en_d;
  logic [DIV_WIDTH-1:0]       div_q, div_d;
  logic [EW-1:0]              div_ext;
  state_t                     state;
  logic [IW-1:0]              idx, idx_inc;
  logic [CW-1:0]              cnt, cnt_load;

  function automatic logic [7:0] seg_of(input logic [5:0] d);
    logic [7:0] r;
    case (d[3:0])
      4'h0: r = 8'hC0; 4'h1: r = 8'hF9; 4'h2: r = 8'hA4; 4'h3: r = 8'hB0;
      4'h4: r = 8'h99; 4'h5: r = 8'h92; 4'h6: r = 8'h82; 4'h7: r = 8'hF8;
      4'h8: r = 8'h80; 4'h9: r = 8'h90; 4'hA: r = 8'h88; 4'hB: r = 8'h83;
      4'hC: r = 8'hC6; 4'hD: r = 8'hA1; 4'hE: r = 8'h86; default: r = 8'h8E;
    endcase
    if (d[4]) r[7] = 1'b0;
    if (d[5]) r = 8'hFF;
    return r;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] sel(input logic [IW-1:0] i);
    return ~(NUM_DIGITS'(1) << i);
  endfunction

  // Register file next values. Digit and enable writes are forwarded into the
  // output/state update so they show up the cycle right after the write.
  always_comb begin
    dig_d   = dig_q;
    en_d    = en_q;
    div_ext = EW'(div_q);
    if (wr_en) begin
      if (wr_addr < 4'(NUM_DIGITS)) dig_d[wr_addr[IW-1:0]] = wr_data[5:0];
      if (wr_addr == 4'd8)  en_d = wr_data[0];
      if (wr_addr == 4'd9)  div_ext[7:0]  = wr_data;
      if (wr_addr == 4'd10) div_ext[15:8] = wr_data;
    end
    div_d    = div_ext[DIV_WIDTH-1:0];
    // dwell load uses the registered div, so a div write lands at the next load
    cnt_load = (div_q == '0) ? '0 : CW'(div_q - 1'b1);
    idx_inc  = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dig_q       <= '0;
      en_q        <= 1'b1;
      div_q       <= DIV_WIDTH'(DEFAULT_DIV);
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      an          <= '1;
      seg         <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      dig_q       <= dig_d;
      en_q        <= en_d;
      div_q       <= div_d;
      frame_start <= 1'b0;
      if (!en_d) begin
        // disable overrides whatever transition was due this cycle
        state <= IDLE;
        an    <= '1;
        seg   <= 8'hFF;
      end else begin
        case (state)
          IDLE: begin
            state       <= SHOW;
            idx         <= '0;
            cnt         <= cnt_load;
            an          <= sel('0);
            seg         <= seg_of(dig_d[0]);
            frame_start <= 1'b1;
          end
          SHOW: begin
            if (cnt == '0) begin
              state <= GAP;
              cnt   <= CW'(GAP_CYCLES - 1);
              an    <= '1;
              seg   <= 8'hFF;
            end else begin
              cnt <= cnt - 1'b1;
              seg <= seg_of(dig_d[idx]);
            end
          end
          GAP: begin
            if (cnt == '0) begin
              state       <= SHOW;
              idx         <= idx_inc;
              cnt         <= cnt_load;
              an          <= sel(idx_inc);
              seg         <= seg_of(dig_d[idx_inc]);
              frame_start <= (idx_inc == '0);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            an    <= '1;
            seg   <= 8'hFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed scenarios followed by random register
// traffic, every cycle compared against a slot-based reference model.
module tb_seven_seg_scan_ctrl;
  localparam int N   = 4;
  localparam int DEF = 50000;
  localparam int GAP = 2;

  logic         clk = 1'b0;
  logic         reset, wr_en;
  logic [3:0]   wr_addr;
  logic [7:0]   wr_data;
  logic [N-1:0] an;
  logic [7:0]   seg;
  logic         frame_start;

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .DIV_WIDTH(16), .DEFAULT_DIV(DEF),
                        .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .an(an), .seg(seg), .frame_start(frame_start));

  always #5 clk = ~clk;

  logic [7:0] DEC [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // model: mode 0 = off, 1 = showing a digit, 2 = blank gap;
  // m_left = cycles remaining in the current slot including this one
  int         m_mode, m_idx, m_left, m_div;
  bit         m_fs, m_en;
  logic [7:0] m_dig [N];
  int         n_pass = 0, n_fail = 0, n_tot = 0;

  task automatic model_step(input logic r, input logic we, input logic [3:0] a,
                            input logic [7:0] d);
    bit nen; int ndiv; int len;
    if (r) begin
      m_mode = 0; m_idx = 0; m_left = 0; m_fs = 0;
      m_en = 1; m_div = DEF;
      for (int i = 0; i < N; i++) m_dig[i] = 8'h00;
      return;
    end
    nen = m_en; ndiv = m_div;
    if (we) begin
      if (a < N) m_dig[a] = d;
      if (a == 8)  nen  = d[0];
      if (a == 9)  ndiv = (m_div & 'hFF00) | d;
      if (a == 10) ndiv = (m_div & 'h00FF) | (int'(d) << 8);
    end
    len  = (m_div == 0) ? 1 : m_div;
    m_fs = 0;
    if (!nen) m_mode = 0;
    else if (m_mode == 0) begin m_mode = 1; m_idx = 0; m_left = len; m_fs = 1; end
    else if (m_left > 1) m_left--;
    else if (m_mode == 1) begin m_mode = 2; m_left = GAP; end
    else begin
      m_idx = (m_idx + 1) % N; m_mode = 1; m_left = len; m_fs = (m_idx == 0);
    end
    m_en = nen; m_div = ndiv;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input logic we, input logic [3:0] a,
                      input logic [7:0] d);
    logic [N-1:0] ea; logic [7:0] es;
    reset = r; wr_en = we; wr_addr = a; wr_data = d;
    @(posedge clk);
    model_step(r, we, a, d);
    @(negedge clk);
    ea = '1; es = 8'hFF;
    if (m_mode == 1) begin
      ea[m_idx] = 1'b0;
      if (!m_dig[m_idx][5]) es = DEC[m_dig[m_idx][3:0]] & (m_dig[m_idx][4] ? 8'h7F : 8'hFF);
    end
    chk("an", 32'(an), 32'(ea));
    chk("seg", 32'(seg), 32'(es));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 4'd0, 8'h00);
  endtask

  task automatic seek(input int mode, input int ix, input int left, input string tag);
    int k = 0;
    while (!(m_mode == mode && m_idx == ix && m_left == left) && k < 200) begin
      tick(0, 0, 4'd0, 8'h00); k++;
    end
    n_tot++;
    assert (k < 200) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: seek took %0d cycles, required < 200", tag, k);
    end
  endtask

  initial begin
    // reset held two cycles, then first SHOW of digit 0 with defaults
    tick(1, 0, 4'd0, 8'h00);
    tick(1, 0, 4'd0, 8'h00);
    tick(0, 0, 4'd0, 8'h00);
    chk("first_an", 32'(an), 32'(4'b1110));
    chk("first_seg", 32'(seg), 32'h C0);

    // div = 3, digits 1..4, restart the scan so the new div loads
    tick(0, 1, 4'd9,  8'h03);
    tick(0, 1, 4'd10, 8'h00);
    tick(0, 1, 4'd0, 8'h01);
    tick(0, 1, 4'd1, 8'h02);
    tick(0, 1, 4'd2, 8'h03);
    tick(0, 1, 4'd3, 8'h04);
    tick(0, 1, 4'd8, 8'h00);
    idle(2);
    tick(0, 1, 4'd8, 8'h01);
    idle(45);

    // mid-SHOW dp+A write to digit 0
    seek(1, 0, 2, "seek_mid_show");
    tick(0, 1, 4'd0, 8'h1A);
    chk("dp_a_seg", 32'(seg), 32'h08);
    idle(4);

    // blank digit 2, written in the last gap cycle before it
    seek(2, 1, 1, "seek_gap_before_2");
    tick(0, 1, 4'd2, 8'h20);
    chk("blank_an", 32'(an), 32'(4'b1011));
    idle(20);

    // disable on a SHOW terminal count, then re-enable
    seek(1, 3, 1, "seek_terminal");
    tick(0, 1, 4'd8, 8'h00);
    chk("disabled_an", 32'(an), 32'(4'b1111));
    idle(5);
    tick(0, 1, 4'd8, 8'h01);
    chk("resume_fs", 32'(frame_start), 32'd1);
    idle(25);

    // div = 0 behaves as 1: 12-cycle frame, then reset mid-frame
    tick(0, 1, 4'd9, 8'h00);
    tick(0, 1, 4'd8, 8'h00);
    tick(0, 1, 4'd8, 8'h01);
    idle(31);
    tick(1, 0, 4'd0, 8'h00);
    chk("reset_mid_an", 32'(an), 32'(4'b1111));
    idle(30);

    // random register traffic with a small div
    tick(0, 1, 4'd9, 8'(($urandom % 4) + 1));
    tick(0, 1, 4'd8, 8'h00);
    for (int c = 0; c < 500; c++) begin
      logic [3:0] a; logic [7:0] d;
      if (($urandom % 6) == 0) begin
        a = 4'($urandom % 12);
        d = 8'($urandom);
        if (a == 4'd8)  d[0] = (($urandom % 8) != 0);
        if (a == 4'd9)  d = 8'($urandom % 6);
        if (a == 4'd10) d = 8'h00;
        tick(0, 1, a, d);
      end else begin
        tick(0, 0, 4'd0, 8'h00);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
